data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Two-master arbiter and sequencer for the single-port data memory and its memory-mapped I/O window (253 display, 254 button, 255 switches).
- Master 0 is the processor datapath. Master 1 is the program/debug loader.
- Grants the memory port using a registered round-robin state machine, with optional bounded locking.
- Returns registered read data with a valid pulse and suppresses illegal writes to the read-only I/O addresses.

Parameters:
- N, 8, data width (bits)
- M, 8, address width (bits); the I/O window is the top three addresses 2**M-3 .. 2**M-1
- LOCK_MAX, 4, maximum consecutive grant cycles a locking master keeps the port while the other master is requesting

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- m0_req, m1_req  in  1  access request; held until the grant cycle
- m0_we, m1_we  in  1  1 = write, 0 = read
- m0_addr, m1_addr  in  M  address
- m0_wdata, m1_wdata  in  N  write data
- m0_lock, m1_lock  in  1  request to keep ownership on the next cycle
- m0_gnt, m1_gnt  out  1  access performed this cycle
- m0_rdata, m1_rdata  out  N  registered read data
- m0_rvalid, m1_rvalid  out  1  one-cycle pulse: rdata is valid
- mem_Addr  out  M  to memory Addr
- mem_WriteData  out  N  to memory WriteData
- mem_WE  out  1  to memory WE
- mem_ReadData  in  N  from memory ReadData (combinational read)
- owner  out  2  00 = idle, 01 = master 0, 10 = master 1
- io_err  out  1  one-cycle pulse: write to a read-only I/O address was suppressed

Behaviour:
- Reset: rst_n sampled low at the clk edge forces the following, regardless of state or an in-flight access:
  - state = IDLE, owner = 00, lock count = 0, last = 1 (master 0 wins the first tie)
  - all gnt, rvalid, io_err, mem_WE = 0; mem_Addr, mem_WriteData, rdata = 0
  - the access in the reset cycle is not performed.
- States: IDLE, OWN0, OWN1. The state is registered; gnt and the mem_* outputs are combinational from state and the owner's inputs.
- IDLE:
  - mem_WE = 0, mem_Addr = 0, no gnt.
  - Next state: both requesting → OWN of the master opposite to last; one requesting → that master; none → IDLE.
  - Latency: req asserted in cycle t while IDLE → gnt in cycle t+1.
- OWNx:
  - mem_Addr = mx_addr, mem_WriteData = mx_wdata, mx_gnt = mx_req.
  - mem_WE = mx_req & mx_we & ~ro_hit, where ro_hit = (addr == 2**M-2) | (addr == 2**M-1).
  - The memory write occurs at the end of the grant cycle.
- Read return:
  - A grant cycle with we = 0 → in the next cycle, mx_rdata = the registered mem_ReadData and mx_rvalid = 1.
  - Otherwise rvalid = 0 and rdata holds its last value.
- io_err: pulses 1 in the cycle after a granted write with ro_hit. No memory write happens and there is no rvalid.
- Writes to the display address (2**M-3) pass through normally.
- lock count: number of grant cycles already used in the current tenure. It increments each grant cycle, resets to 0 on every ownership change, and saturates at LOCK_MAX.
- Next state from OWNx:
  - ~mx_req → OWN other if the other master requests, else IDLE.
  - mx_req & ~other_req → stay in OWNx.
  - mx_req & other_req & mx_lock & (cnt+1 < LOCK_MAX) → stay in OWNx.
  - mx_req & other_req, otherwise → OWN other.
- last updates to x whenever the state leaves OWNx.
- Hand-off is back-to-back: there is no idle cycle between OWN0 and OWN1.
- A master must hold req, we, addr, and wdata stable until its gnt. Changes before the grant are undefined for that master.
- Simultaneous events:
  - A master dropping req in the same cycle the other asserts req → hand-off on the next edge.
  - Lock with no competitor: ownership is held indefinitely and the count saturates.

Test Plan:
- m0 write addr 10 = 0x5A, then read addr 10 → gnt one cycle after req; mem_WE = 1 in the write grant cycle; m0_rvalid = 1 and m0_rdata = 0x5A one cycle after the read grant.
- m0 and m1 continuously request, no lock, from reset → grants alternate m0, m1, m0, m1 with no idle cycle; owner toggles 01/10.
- Both request, m1_lock = 1, LOCK_MAX = 4, m1 owns → m1_gnt for exactly 4 consecutive cycles, then m0_gnt; with m0 idle, m1 is held indefinitely.
- m0 writes 0x33 to addr 255 and then to 254 → mem_WE = 0 in both grant cycles, io_err pulses twice, no rvalid; a write to 253 gives mem_WE = 1 and no io_err.
- m0 reads 255 with the switch input 0xC3 → m0_rvalid = 1 and m0_rdata = 0xC3 one cycle after the grant.
- rst_n = 0 during an m1 write grant → no write to memory, owner = 00, all outputs 0; with both masters requesting after release, the first grant goes to m0.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Two-master round-robin arbiter and sequencer for the single-port data memory
// and its I/O window (display / button / switches at the top three addresses).
module data_mem_arbiter #(
   parameter int N        = 8,
   parameter int M        = 8,
   parameter int LOCK_MAX = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         m0_req,
   input  logic         m1_req,
   input  logic         m0_we,
   input  logic         m1_we,
   input  logic [M-1:0] m0_addr,
   input  logic [M-1:0] m1_addr,
   input  logic [N-1:0] m0_wdata,
   input  logic [N-1:0] m1_wdata,
   input  logic         m0_lock,
   input  logic         m1_lock,
   output logic         m0_gnt,
   output logic         m1_gnt,
   output logic [N-1:0] m0_rdata,
   output logic [N-1:0] m1_rdata,
   output logic         m0_rvalid,
   output logic         m1_rvalid,
   output logic [M-1:0] mem_Addr,
   output logic [N-1:0] mem_WriteData,
   output logic         mem_WE,
   input  logic [N-1:0] mem_ReadData,
   output logic [1:0]   owner,
   output logic         io_err
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } state_t;

   localparam int CW = $clog2(LOCK_MAX + 1);

   state_t         state;
   state_t         oth_state;
   logic           last;
   logic [CW-1:0]  cnt;

   logic           own_req;
   logic           own_we;
   logic           own_lock;
   logic           oth_req;
   logic [M-1:0]   own_addr;
   logic [N-1:0]   own_wdata;
   logic           ro_hit;
   logic           acc;
   logic           lock_ok;
   logic           hold;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path infers a latch.
      own_req   = 1'b0;
      own_we    = 1'b0;
      own_lock  = 1'b0;
      oth_req   = 1'b0;
      own_addr  = '0;
      own_wdata = '0;
      case (state)
         OWN0: begin
            own_req   = m0_req;
            own_we    = m0_we;
            own_lock  = m0_lock;
            oth_req   = m1_req;
            own_addr  = m0_addr;
            own_wdata = m0_wdata;
         end
         OWN1: begin
            own_req   = m1_req;
            own_we    = m1_we;
            own_lock  = m1_lock;
            oth_req   = m0_req;
            own_addr  = m1_addr;
            own_wdata = m1_wdata;
         end
         default: ;
      endcase
   end

   // Button and switches are read-only; the display just below them is writable.
   assign ro_hit    = &own_addr[M-1:1];
   assign acc       = own_req & rst_n;
   assign oth_state = (state == OWN0) ? OWN1 : OWN0;
   assign lock_ok   = (int'(cnt) + 1) < LOCK_MAX;
   assign hold      = own_req & (~oth_req | (own_lock & lock_ok));

   assign m0_gnt        = acc & (state == OWN0);
   assign m1_gnt        = acc & (state == OWN1);
   assign mem_Addr      = own_addr;
   assign mem_WriteData = own_wdata;
   assign mem_WE        = acc & own_we & ~ro_hit;
   assign owner         = state;

   always_ff @(posedge clk) begin
      // NOTE: sequential state is assigned non-blocking so every register samples pre-edge values.
      if (!rst_n) begin
         state     <= IDLE;
         last      <= 1'b1;
         cnt       <= '0;
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
         io_err    <= 1'b0;
      end else begin
         m0_rvalid <= m0_gnt & ~m0_we;
         m1_rvalid <= m1_gnt & ~m1_we;
         if (m0_gnt && !m0_we) m0_rdata <= mem_ReadData;
         if (m1_gnt && !m1_we) m1_rdata <= mem_ReadData;
         io_err <= acc & own_we & ro_hit;

         case (state)
            IDLE: begin
               cnt <= '0;
               if (m0_req && m1_req) state <= last ? OWN0 : OWN1;
               else if (m0_req)      state <= OWN0;
               else if (m1_req)      state <= OWN1;
            end
            default: begin
               if (hold) begin
                  if (cnt != CW'(LOCK_MAX)) cnt <= cnt + 1'b1;
               end else begin
                  // Leaving a tenure: remember who had it so the next tie goes the other way.
                  state <= oth_req ? oth_state : IDLE;
                  cnt   <= '0;
                  last  <= (state == OWN1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
module tb_data_mem_arbiter;

   localparam int N        = 8;
   localparam int M        = 8;
   localparam int LOCK_MAX = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req   [2];
   logic       we    [2];
   logic [7:0] addr  [2];
   logic [7:0] wdata [2];
   logic       lock  [2];
   logic [7:0] sw;
   logic [7:0] btn;

   logic       m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_WE, io_err;
   logic [7:0] m0_rdata, m1_rdata, mem_Addr, mem_WriteData, mem_ReadData;
   logic [1:0] owner;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   data_mem_arbiter #(.N(N), .M(M), .LOCK_MAX(LOCK_MAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(req[0]), .m1_req(req[1]),
      .m0_we(we[0]), .m1_we(we[1]),
      .m0_addr(addr[0]), .m1_addr(addr[1]),
      .m0_wdata(wdata[0]), .m1_wdata(wdata[1]),
      .m0_lock(lock[0]), .m1_lock(lock[1]),
      .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
      .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
      .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
      .mem_Addr(mem_Addr), .mem_WriteData(mem_WriteData), .mem_WE(mem_WE),
      .mem_ReadData(mem_ReadData),
      .owner(owner), .io_err(io_err)
   );

   // Environment: the physical memory plus the two input-only I/O registers.
   logic [7:0] env_mem [256] = '{default: 8'h00};
   assign mem_ReadData = (mem_Addr == 8'd255) ? sw :
                         (mem_Addr == 8'd254) ? btn : env_mem[mem_Addr];
   always @(posedge clk) if (mem_WE) env_mem[mem_Addr] <= mem_WriteData;

   // Reference model: who owns the port, how long, and what each access must return.
   int         m_own     = -1;
   int         m_tenure  = 0;
   int         m_last    = 1;
   bit         m_granted [2];
   logic       x_rvalid  [2];
   logic [7:0] x_rdata   [2];
   logic       x_ioerr;
   logic [7:0] ref_mem   [256] = '{default: 8'h00};

   function automatic int choose(input int own, input int tenure, input int lst,
                                 input bit r0, input bit r1, input bit l0, input bit l1);
      bit r [2];
      bit l [2];
      r[0] = r0; r[1] = r1; l[0] = l0; l[1] = l1;
      if (own < 0) begin
         if (r[0] && r[1]) return 1 - lst;
         if (r[0]) return 0;
         if (r[1]) return 1;
         return -1;
      end
      if (!r[own])   return r[1-own] ? 1 - own : -1;
      if (!r[1-own]) return own;
      if (l[own] && tenure + 1 < LOCK_MAX) return own;
      return 1 - own;
   endfunction

   function automatic logic [7:0] read_value(input logic [7:0] a);
      if (a == 8'd255) return sw;
      if (a == 8'd254) return btn;
      return ref_mem[a];
   endfunction

   always @(posedge clk) begin : model
      int nxt;
      bit o;
      if (!rst_n) begin
         m_own = -1; m_tenure = 0; m_last = 1; x_ioerr = 1'b0;
         for (int i = 0; i < 2; i++) begin
            m_granted[i] = 1'b0; x_rvalid[i] = 1'b0; x_rdata[i] = 8'h00;
         end
      end else begin
         x_ioerr = 1'b0;
         for (int i = 0; i < 2; i++) begin
            m_granted[i] = 1'b0; x_rvalid[i] = 1'b0;
         end
         o = m_own[0];
         if (m_own >= 0 && req[o]) begin
            m_granted[o] = 1'b1;
            if (we[o]) begin
               if (addr[o] >= 8'd254) x_ioerr = 1'b1;
               else ref_mem[addr[o]] = wdata[o];
            end else begin
               x_rvalid[o] = 1'b1;
               x_rdata[o]  = read_value(addr[o]);
            end
         end
         nxt = choose(m_own, m_tenure, m_last, req[0], req[1], lock[0], lock[1]);
         if (nxt >= 0 && nxt == m_own) m_tenure = (m_tenure < LOCK_MAX) ? m_tenure + 1 : LOCK_MAX;
         else                          m_tenure = 0;
         if (m_own >= 0 && nxt != m_own) m_last = m_own;
         m_own = nxt;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      logic [7:0] e_addr;
      logic       e_g0, e_g1, e_we;
      bit         o;
      e_addr = 8'h00; e_g0 = 1'b0; e_g1 = 1'b0; e_we = 1'b0;
      o = m_own[0];
      if (m_own >= 0) begin
         e_addr = addr[o];
         check("mem_WriteData", 32'(mem_WriteData), 32'(wdata[o]));
         if (rst_n && req[o]) begin
            if (o) e_g1 = 1'b1; else e_g0 = 1'b1;
            e_we = we[o] && (addr[o] < 8'd254);
         end
      end
      check("owner", 32'(owner), 32'(m_own + 1));
      check("m0_gnt", 32'(m0_gnt), 32'(e_g0));
      check("m1_gnt", 32'(m1_gnt), 32'(e_g1));
      check("mem_WE", 32'(mem_WE), 32'(e_we));
      check("mem_Addr", 32'(mem_Addr), 32'(e_addr));
      check("m0_rvalid", 32'(m0_rvalid), 32'(x_rvalid[0]));
      check("m1_rvalid", 32'(m1_rvalid), 32'(x_rvalid[1]));
      check("m0_rdata", 32'(m0_rdata), 32'(x_rdata[0]));
      check("m1_rdata", 32'(m1_rdata), 32'(x_rdata[1]));
      check("io_err", 32'(io_err), 32'(x_ioerr));
   endtask

   task automatic tick();
      @(negedge clk);
      compare_all();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_m(input int i, input bit r, input bit w, input logic [7:0] a,
                        input logic [7:0] d, input bit l);
      req[i] = r; we[i] = w; addr[i] = a; wdata[i] = d; lock[i] = l;
   endtask

   task automatic idle_all();
      set_m(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      set_m(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_all();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic rand_req(input int i);
      int         r;
      logic [7:0] a;
      r = $urandom_range(0, 7);
      a = (r < 6) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(253, 255));
      set_m(i, 1'b1, 1'($urandom_range(0, 1)), a, 8'($urandom), lock[i]);
   endtask

   initial begin
      rst_n = 1'b0;
      sw    = 8'h00;
      btn   = 8'h00;
      idle_all();

      // Reset state
      do_reset();
      settle();
      check("rst owner", 32'(owner), 32'd0);
      check("rst gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
      check("rst mem_WE", 32'(mem_WE), 32'd0);
      check("rst rdata", 32'({m0_rdata, m1_rdata}), 32'd0);

      // m0 write 10 = 0x5A, then read it back
      set_m(0, 1'b1, 1'b1, 8'd10, 8'h5A, 1'b0);
      settle();
      check("t1 no gnt while idle", 32'(m0_gnt), 32'd0);
      tick(); settle();
      check("t1 write gnt", 32'(m0_gnt), 32'd1);
      check("t1 write WE", 32'(mem_WE), 32'd1);
      check("t1 write addr", 32'(mem_Addr), 32'd10);
      tick(); set_m(0, 1'b1, 1'b0, 8'd10, 8'h00, 1'b0); settle();
      check("t1 read gnt", 32'(m0_gnt), 32'd1);
      check("t1 read WE", 32'(mem_WE), 32'd0);
      tick(); set_m(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0); settle();
      check("t1 rvalid", 32'(m0_rvalid), 32'd1);
      check("t1 rdata", 32'(m0_rdata), 32'h5A);

      // Continuous requests without lock alternate back-to-back
      do_reset();
      set_m(0, 1'b1, 1'b0, 8'd3, 8'h00, 1'b0);
      set_m(1, 1'b1, 1'b0, 8'd4, 8'h00, 1'b0);
      settle();
      for (int k = 0; k < 6; k++) begin
         tick(); settle();
         check("t2 m0_gnt", 32'(m0_gnt), (k % 2 == 0) ? 32'd1 : 32'd0);
         check("t2 m1_gnt", 32'(m1_gnt), (k % 2 == 0) ? 32'd0 : 32'd1);
         check("t2 owner", 32'(owner), (k % 2 == 0) ? 32'd1 : 32'd2);
      end

      // m1 locks against a competing m0, then holds with no competitor
      do_reset();
      set_m(0, 1'b1, 1'b0, 8'd5, 8'h00, 1'b0);
      set_m(1, 1'b1, 1'b0, 8'd6, 8'h00, 1'b1);
      settle();
      tick(); settle();
      check("t3 m0 first", 32'(m0_gnt), 32'd1);
      for (int k = 0; k < 4; k++) begin
         tick(); settle();
         check("t3 m1 locked gnt", 32'(m1_gnt), 32'd1);
         check("t3 m0 waits", 32'(m0_gnt), 32'd0);
      end
      tick(); settle();
      check("t3 m0 after lock", 32'(m0_gnt), 32'd1);
      tick(); set_m(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0); settle();
      for (int k = 0; k < 8; k++) begin
         check("t3 m1 held owner", 32'(owner), 32'd2);
         check("t3 m1 held gnt", 32'(m1_gnt), 32'd1);
         tick(); settle();
      end
      set_m(0, 1'b1, 1'b0, 8'd5, 8'h00, 1'b0);
      settle();
      check("t3 m1 still owns", 32'(m1_gnt), 32'd1);
      tick(); settle();
      check("t3 saturated handoff", 32'(m0_gnt), 32'd1);

      // Writes to the read-only I/O addresses are suppressed; display passes
      do_reset();
      set_m(0, 1'b1, 1'b1, 8'd255, 8'h33, 1'b0);
      settle();
      tick(); settle();
      check("t4 gnt 255", 32'(m0_gnt), 32'd1);
      check("t4 WE 255", 32'(mem_WE), 32'd0);
      tick(); set_m(0, 1'b1, 1'b1, 8'd254, 8'h33, 1'b0); settle();
      check("t4 io_err 255", 32'(io_err), 32'd1);
      check("t4 WE 254", 32'(mem_WE), 32'd0);
      tick(); set_m(0, 1'b1, 1'b1, 8'd253, 8'h33, 1'b0); settle();
      check("t4 io_err 254", 32'(io_err), 32'd1);
      check("t4 no rvalid", 32'(m0_rvalid), 32'd0);
      check("t4 WE 253", 32'(mem_WE), 32'd1);
      tick(); set_m(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0); settle();
      check("t4 no io_err 253", 32'(io_err), 32'd0);

      // Read of the switch input
      do_reset();
      sw = 8'hC3;
      set_m(0, 1'b1, 1'b0, 8'd255, 8'h00, 1'b0);
      settle();
      tick(); settle();
      check("t5 gnt", 32'(m0_gnt), 32'd1);
      tick(); set_m(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0); settle();
      check("t5 rvalid", 32'(m0_rvalid), 32'd1);
      check("t5 rdata", 32'(m0_rdata), 32'hC3);

      // Reset during an m1 write grant
      do_reset();
      set_m(1, 1'b1, 1'b1, 8'd20, 8'h77, 1'b0);
      settle();
      tick(); rst_n = 1'b0; settle();
      check("t6 gnt in reset", 32'(m1_gnt), 32'd0);
      check("t6 WE in reset", 32'(mem_WE), 32'd0);
      tick(); settle();
      check("t6 owner", 32'(owner), 32'd0);
      check("t6 outputs", 32'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, io_err, mem_WE}), 32'd0);
      check("t6 mem untouched", 32'(env_mem[20]), 32'h00);
      rst_n = 1'b1;
      set_m(0, 1'b1, 1'b0, 8'd1, 8'h00, 1'b0);
      settle();
      tick(); settle();
      check("t6 m0 wins first", 32'(m0_gnt), 32'd1);
      check("t6 m1 waits", 32'(m1_gnt), 32'd0);

      // Randomized traffic, checked against the model every cycle
      idle_all();
      for (int c = 0; c < 3000; c++) begin
         tick();
         rst_n = ($urandom_range(0, 199) != 0);
         for (int i = 0; i < 2; i++) begin
            lock[i] = 1'($urandom_range(0, 1));
            if (!req[i] || m_granted[i]) begin
               if ($urandom_range(0, 3) != 0) rand_req(i);
               else set_m(i, 1'b0, 1'b0, 8'h00, 8'h00, lock[i]);
            end
         end
         if ($urandom_range(0, 15) == 0) sw  = 8'($urandom);
         if ($urandom_range(0, 15) == 0) btn = 8'($urandom);
      end
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
